// File: rtl/oser_sc_pkg.sv
// oser_sc_pkg: state encoding and legal width range for the oser_sc transmitter
package oser_sc_pkg;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 8;
endpackage

// File: rtl/oser_sc.sv
// oser_sc: single-clock N:1 parallel-to-serial transmitter with word-request handshake
module oser_sc
    import oser_sc_pkg::*;
#(
    parameter int   WIDTH     = 4,
    parameter logic INIT      = 1'b1,
    parameter logic LSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    output logic             DREQ,
    output logic             Q,
    output logic             ACTIVE
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_bad
        $error("oser_sc: WIDTH must be in 2..8");
    end
    state_e           state_q = IDLE;
    logic [CW-1:0]    cnt_q   = '0;
    logic [WIDTH-2:0] sh_q    = '0;
    logic             q_q     = INIT;
    state_e           state_d;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-2:0] sh_d;
    logic [WIDTH-2:0] rest;
    logic             q_d;
    logic             load;
    logic             step;
    assign DREQ   = state_q == IDLE || cnt_q == LAST;
    assign ACTIVE = state_q == SHIFT;
    assign Q      = q_q;
    // next state: sh always holds the pending bits in transmit order, next bit at sh[0]
    always_comb begin
        rest = '0;
        for (int i = 0; i < WIDTH - 1; i++) rest[i] = LSB_FIRST ? D[i + 1] : D[WIDTH - 2 - i];
        load    = DREQ && EN;
        step    = state_q == SHIFT && cnt_q != LAST;
        state_d = load || step ? SHIFT : IDLE;
        cnt_d   = step ? cnt_q + CW'(1) : '0;
        sh_d    = load ? rest : step ? sh_q >> 1 : sh_q;
        q_d     = load ? (LSB_FIRST ? D[0] : D[WIDTH-1]) : step ? sh_q[0] : INIT;
    end
    // state, bit counter and shift register; reset aborts any word in flight
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end
    // registered serial output, idles at INIT
    always_ff @(posedge CLK) begin
        q_q <= RESET ? INIT : q_d;
    end
endmodule

// File: tb/tb_oser_sc.sv
// tb_oser_sc: directed self-checking bench for oser_sc across four parameter sets
module tb_oser_sc;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0, en_d = 1'b0;
    logic [3:0] d_a = '0;
    logic [7:0] d_b = '0;
    logic [1:0] d_c = '0;
    logic [2:0] d_d = '0;
    logic dreq_a, q_a, act_a, dreq_b, q_b, act_b, dreq_c, q_c, act_c, dreq_d, q_d, act_d;
    int checks = 0;
    int errors = 0;
    oser_sc #(.WIDTH(4), .INIT(1'b1), .LSB_FIRST(1'b1)) u_a (
        .CLK(clk), .RESET(rst), .EN(en_a), .D(d_a), .DREQ(dreq_a), .Q(q_a), .ACTIVE(act_a));
    oser_sc #(.WIDTH(8), .INIT(1'b1), .LSB_FIRST(1'b0)) u_b (
        .CLK(clk), .RESET(rst), .EN(en_b), .D(d_b), .DREQ(dreq_b), .Q(q_b), .ACTIVE(act_b));
    oser_sc #(.WIDTH(2), .INIT(1'b0), .LSB_FIRST(1'b1)) u_c (
        .CLK(clk), .RESET(rst), .EN(en_c), .D(d_c), .DREQ(dreq_c), .Q(q_c), .ACTIVE(act_c));
    oser_sc #(.WIDTH(3), .INIT(1'b1), .LSB_FIRST(1'b0)) u_d (
        .CLK(clk), .RESET(rst), .EN(en_d), .D(d_d), .DREQ(dreq_d), .Q(q_d), .ACTIVE(act_d));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask
    initial begin
        logic [11:0] sa;
        logic [15:0] sb;
        logic [3:0]  sc;
        logic [3:0]  wa [3];
        sa = 12'hC5A;
        sb = 16'h813C;
        sc = 4'b0110;
        wa[0] = 4'hA; wa[1] = 4'h5; wa[2] = 4'hC;
        #1;
        chk("pwr_q_a", q_a, 1'b1); chk("pwr_dreq_a", dreq_a, 1'b1); chk("pwr_act_a", act_a, 1'b0);
        chk("pwr_q_c", q_c, 1'b0);
        rst = 1'b1; en_a = 1'b1; en_b = 1'b1; en_c = 1'b1; en_d = 1'b1;
        d_a = 4'hF; d_b = 8'hFF; d_c = 2'b11; d_d = 3'b111;
        for (int r = 0; r < 2; r++) begin
            tick();
            chk($sformatf("rst%0d_q_a", r), q_a, 1'b1);
            chk($sformatf("rst%0d_dreq_a", r), dreq_a, 1'b1);
            chk($sformatf("rst%0d_act_a", r), act_a, 1'b0);
            chk($sformatf("rst%0d_act_b", r), act_b, 1'b0);
            chk($sformatf("rst%0d_q_c", r), q_c, 1'b0);
            chk($sformatf("rst%0d_act_d", r), act_d, 1'b0);
        end
        rst = 1'b0; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
        tick();
        chk("idle_q_a", q_a, 1'b1); chk("idle_act_a", act_a, 1'b0);
        en_a = 1'b1; d_a = 4'b0110;
        tick();
        chk("sw_b0", q_a, 1'b0); chk("sw_act", act_a, 1'b1); chk("sw_dreq0", dreq_a, 1'b0);
        en_a = 1'b1; d_a = 4'hF;
        tick();
        chk("sw_b1", q_a, 1'b1); chk("sw_dreq1", dreq_a, 1'b0);
        en_a = 1'b0; d_a = 4'h0;
        tick();
        chk("sw_b2", q_a, 1'b1);
        en_a = 1'b1; d_a = 4'h9;
        tick();
        chk("sw_b3", q_a, 1'b0); chk("sw_dreq3", dreq_a, 1'b1);
        en_a = 1'b0;
        tick();
        chk("sw_end_q", q_a, 1'b1); chk("sw_end_dreq", dreq_a, 1'b1); chk("sw_end_act", act_a, 1'b0);
        en_a = 1'b1;
        for (int j = 0; j < 12; j++) begin
            d_a = wa[j / 4];
            tick();
            chk($sformatf("st_q%0d", j), q_a, sa[j]);
            chk($sformatf("st_dreq%0d", j), dreq_a, j % 4 == 3);
        end
        en_a = 1'b0;
        tick();
        chk("st_end_q", q_a, 1'b1); chk("st_end_act", act_a, 1'b0); chk("st_end_dreq", dreq_a, 1'b1);
        en_a = 1'b1; d_a = 4'h0;
        tick();
        chk("mr_b0", q_a, 1'b0);
        en_a = 1'b0;
        tick();
        chk("mr_b1", q_a, 1'b0);
        rst = 1'b1;
        tick();
        chk("mr_rst_q", q_a, 1'b1); chk("mr_rst_act", act_a, 1'b0); chk("mr_rst_dreq", dreq_a, 1'b1);
        rst = 1'b0; en_a = 1'b1; d_a = 4'hE;
        tick();
        chk("mr_re_b0", q_a, 1'b0); chk("mr_re_act", act_a, 1'b1);
        en_a = 1'b0;
        tick(); chk("mr_re_b1", q_a, 1'b1);
        tick(); chk("mr_re_b2", q_a, 1'b1);
        tick(); chk("mr_re_b3", q_a, 1'b1); chk("mr_re_dreq", dreq_a, 1'b1);
        tick(); chk("mr_re_end_act", act_a, 1'b0);
        en_b = 1'b1;
        for (int k = 0; k < 16; k++) begin
            d_b = k < 8 ? 8'h81 : 8'h3C;
            tick();
            chk($sformatf("w8_q%0d", k), q_b, sb[15 - k]);
            chk($sformatf("w8_dreq%0d", k), dreq_b, k % 8 == 7);
        end
        en_b = 1'b0;
        tick();
        chk("w8_end_q", q_b, 1'b1); chk("w8_end_act", act_b, 1'b0);
        en_c = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d_c = k < 2 ? 2'b10 : 2'b01;
            tick();
            chk($sformatf("w2_q%0d", k), q_c, sc[k]);
            chk($sformatf("w2_dreq%0d", k), dreq_c, k % 2 == 1);
        end
        en_c = 1'b0;
        tick();
        chk("w2_end_q", q_c, 1'b0); chk("w2_end_act", act_c, 1'b0); chk("w2_end_dreq", dreq_c, 1'b1);
        en_d = 1'b1; d_d = 3'b011;
        tick();
        chk("w3_a_b0", q_d, 1'b0); chk("w3_a_act", act_d, 1'b1);
        en_d = 1'b0;
        tick(); chk("w3_a_b1", q_d, 1'b1);
        tick(); chk("w3_a_b2", q_d, 1'b1); chk("w3_a_dreq", dreq_d, 1'b1);
        tick(); chk("w3_ur_q", q_d, 1'b1); chk("w3_ur_act", act_d, 1'b0);
        tick(); chk("w3_ur_dreq", dreq_d, 1'b1);
        en_d = 1'b1; d_d = 3'b100;
        tick();
        chk("w3_b_b0", q_d, 1'b1); chk("w3_b_act", act_d, 1'b1);
        en_d = 1'b0;
        tick(); chk("w3_b_b1", q_d, 1'b0);
        tick(); chk("w3_b_b2", q_d, 1'b0);
        tick(); chk("w3_b_end_q", q_d, 1'b1); chk("w3_b_end_act", act_d, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
